// File: rtl/cpu_run_controller_if.sv
// Control/status bundle between the run controller and whoever hosts the CPU.
// Handshake: start is a level request sampled each clk; done is a one-cycle completion strobe.
interface cpu_run_controller_if #(
    parameter int COUNT_WIDTH = 32
);
    logic                   start;
    logic                   cpu_stop;
    logic [1:0]             cpu_error;
    logic                   cpu_reset;
    logic                   cpu_clk_en;
    logic                   running;
    logic                   done;
    logic [1:0]             status;
    logic [1:0]             error_latched;
    logic [COUNT_WIDTH-1:0] cycle_count;

    modport master (
        input  start, cpu_stop, cpu_error,
        output cpu_reset, cpu_clk_en, running, done, status, error_latched, cycle_count
    );

    modport slave (
        output start, cpu_stop, cpu_error,
        input  cpu_reset, cpu_clk_en, running, done, status, error_latched, cycle_count
    );
endinterface

// File: rtl/cpu_run_controller.sv
// Supervises a CPU run: reset hold, gated clock, stop drain, fault/timeout halt, cycle count.
// state_dbg exposes the FSM encoding (IDLE=0 HOLD=1 RUN=2 DRAIN=3 HALTED=4).
module cpu_run_controller #(
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 0,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_run_controller_if.master bus,
    output logic [2:0]           state_dbg
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HOLD   = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam int HW = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
    localparam logic [HW-1:0]          HOLD_LOAD = HW'(RESET_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] LIMIT     = COUNT_WIDTH'(MAX_CYCLES);
    localparam logic                   LIMITED   = (MAX_CYCLES != 0);

    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_STOPPED = 2'd1;
    localparam logic [1:0] ST_ERROR   = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    state_t                 state;
    logic [HW-1:0]          hold_cnt;
    logic                   cpu_reset_q;
    logic                   running_q;
    logic                   done_q;
    logic [1:0]             status_q;
    logic [1:0]             error_q;
    logic [COUNT_WIDTH-1:0] count_q;

    logic                   fault;
    logic                   timeout;
    logic                   clk_en;
    logic [COUNT_WIDTH-1:0] count_next;

    assign fault      = |bus.cpu_error;
    assign timeout    = LIMITED && (count_q == LIMIT) && !bus.cpu_stop;
    assign count_next = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;

    // Clock grant must drop in the same cycle a fault/timeout is seen, so it is combinational.
    always_comb begin
        clk_en = 1'b0;
        case (state)
            HOLD, DRAIN: clk_en = 1'b1;
            RUN:         clk_en = !fault && !timeout;
            default:     clk_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= ST_NONE;
            error_q     <= 2'b00;
            count_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, HALTED: begin
                    if (bus.start) begin
                        state       <= HOLD;
                        hold_cnt    <= HOLD_LOAD;
                        cpu_reset_q <= 1'b1;
                        status_q    <= ST_NONE;
                        error_q     <= 2'b00;
                        count_q     <= '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt <= HW'(1)) begin
                        state       <= RUN;
                        hold_cnt    <= '0;
                        cpu_reset_q <= 1'b0;
                        running_q   <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (fault) begin
                        state     <= HALTED;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        status_q  <= ST_ERROR;
                        error_q   <= bus.cpu_error;
                    end else if (bus.cpu_stop) begin
                        state     <= DRAIN;
                        running_q <= 1'b0;
                        count_q   <= count_next;
                    end else if (timeout) begin
                        state     <= HALTED;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        status_q  <= ST_TIMEOUT;
                    end else begin
                        count_q <= count_next;
                    end
                end
                DRAIN: begin
                    state    <= HALTED;
                    done_q   <= 1'b1;
                    status_q <= ST_STOPPED;
                    count_q  <= count_next;
                end
                default: begin
                    state       <= IDLE;
                    cpu_reset_q <= 1'b1;
                    running_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_reset     = cpu_reset_q;
    assign bus.cpu_clk_en    = clk_en;
    assign bus.running       = running_q;
    assign bus.done          = done_q;
    assign bus.status        = status_q;
    assign bus.error_latched = error_q;
    assign bus.cycle_count   = count_q;
    assign state_dbg         = state;
endmodule
